snitch_vfpr_wb: RTL and testbench

Write-back buffer that sits directly upstream of the vector FP register file write port. It accepts FPU results (destination address plus data), queues them in order and issues each one as a TCDM write request on the register file's write port. It then tracks every write until its response returns. While a write is queued or in flight, it flags read-after-write hazards against the three operand addresses the issue stage is about to read.

---
 rtl/snitch_vfpr_wb.sv | 133 +++++++++++++
 tb/tb_snitch_vfpr_wb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_vfpr_wb.sv
// snitch_vfpr_wb: in-order write-back buffer in front of the vector FP register file write port.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   res_valid_i/ready_o  FPU result handshake; res_addr_i/res_data_i carry the destination and data
//   wr_req_o/wr_rsp_i    TCDM-style write port towards the register file
//   chk_addr_i/chk_en_i  three operand addresses checked for read-after-write hazards -> hazard_o
//   empty_o              nothing queued or in flight
package snitch_vfpr_wb_pkg;
    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2
    } amo_op_e;

    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [63:0] data;
        logic [7:0]  strb;
        amo_op_e     amo;
        logic        user;
    } tcdm_req_chan_t;

    typedef struct packed {
        tcdm_req_chan_t q;
        logic           q_valid;
    } tcdm_req_t;

    typedef struct packed {
        logic [63:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        logic           q_ready;
        logic           p_valid;
        tcdm_rsp_chan_t p;
    } tcdm_rsp_t;
endpackage

module snitch_vfpr_wb #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned Depth     = 4,
    parameter type tcdm_req_t = snitch_vfpr_wb_pkg::tcdm_req_t,
    parameter type tcdm_rsp_t = snitch_vfpr_wb_pkg::tcdm_rsp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    res_valid_i,
    output logic                    res_ready_o,
    input  logic [AddrWidth-1:0]    res_addr_i,
    input  logic [DataWidth-1:0]    res_data_i,
    output tcdm_req_t               wr_req_o,
    input  tcdm_rsp_t               wr_rsp_i,
    input  logic [2:0][AddrWidth-1:0] chk_addr_i,
    input  logic [2:0]              chk_en_i,
    output logic [2:0]              hazard_o,
    output logic                    empty_o
);
    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    logic [AddrWidth-1:0] addr_q [Depth];
    logic [DataWidth-1:0] data_q [Depth];
    logic [PW-1:0] wr_ptr, iss_ptr, ret_ptr;
    logic [CW-1:0] n_total, n_queued;
    logic push, issue, retire;
    logic [Depth-1:0] live;
    logic unused_rsp;

    assign unused_rsp = ^wr_rsp_i.p.data;
    assign res_ready_o = n_total != CW'(Depth);
    assign empty_o = n_total == '0;
    assign push = res_valid_i & res_ready_o;
    assign issue = wr_req_o.q_valid & wr_rsp_i.q_ready;
    // A response with nothing in flight is ignored so state stays consistent.
    assign retire = wr_rsp_i.p_valid & (n_total != n_queued);

    always_comb begin
        wr_req_o = '0;
        wr_req_o.q_valid = n_queued != '0;
        wr_req_o.q.addr = addr_q[iss_ptr];
        wr_req_o.q.data = data_q[iss_ptr];
        wr_req_o.q.write = 1'b1;
        wr_req_o.q.strb = '1;
        wr_req_o.q.amo = snitch_vfpr_wb_pkg::AMONone;
        wr_req_o.q.user = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            iss_ptr  <= '0;
            ret_ptr  <= '0;
            n_total  <= '0;
            n_queued <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (issue) iss_ptr <= iss_ptr + PW'(1);
            if (retire) ret_ptr <= ret_ptr + PW'(1);
            n_total  <= n_total + CW'(push) - CW'(retire);
            n_queued <= n_queued + CW'(push) - CW'(issue);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr] <= res_addr_i;
            data_q[wr_ptr] <= res_data_i;
        end
    end

    // An entry is live when its distance from ret_ptr (modulo Depth) is below n_total.
    always_comb begin
        logic [PW-1:0] off;
        off = '0;
        live = '0;
        for (int i = 0; i < Depth; i++) begin
            off = PW'(i) - ret_ptr;
            live[i] = CW'(off) < n_total;
        end
    end

    always_comb begin
        hazard_o = '0;
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < Depth; i++)
                hazard_o[j] = hazard_o[j] | (chk_en_i[j] & live[i] & (addr_q[i] == chk_addr_i[j]));
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) wr_rsp_i.p_valid |-> n_total != n_queued)
        else $error("snitch_vfpr_wb: write response with no write in flight");
endmodule

// File: tb/tb_snitch_vfpr_wb.sv
// tb_snitch_vfpr_wb: directed bench with a queue-based reference model for snitch_vfpr_wb.
module tb_snitch_vfpr_wb;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic res_valid = 1'b0;
    logic res_ready;
    logic [AW-1:0] res_addr = '0;
    logic [DW-1:0] res_data = '0;
    snitch_vfpr_wb_pkg::tcdm_req_t wr_req;
    snitch_vfpr_wb_pkg::tcdm_rsp_t wr_rsp;
    logic q_ready = 1'b0;
    logic p_valid = 1'b0;
    logic [2:0][AW-1:0] chk_addr = '0;
    logic [2:0] chk_en = '0;
    logic [2:0] hazard;
    logic empty;

    always_comb begin
        wr_rsp = '0;
        wr_rsp.q_ready = q_ready;
        wr_rsp.p_valid = p_valid;
        wr_rsp.p.data = '1;
    end

    snitch_vfpr_wb dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .res_valid_i(res_valid),
        .res_ready_o(res_ready),
        .res_addr_i(res_addr),
        .res_data_i(res_data),
        .wr_req_o(wr_req),
        .wr_rsp_i(wr_rsp),
        .chk_addr_i(chk_addr),
        .chk_en_i(chk_en),
        .hazard_o(hazard),
        .empty_o(empty)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of stored writes in push order; the first m_fl are in flight.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t m[$];
    int m_fl = 0;

    initial begin : model
        bit r, i, p;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m.delete();
                m_fl = 0;
            end else begin
                r = p_valid && m_fl > 0;
                i = (m.size() > m_fl) && q_ready;
                p = res_valid && m.size() < D;
                if (r) begin
                    void'(m.pop_front());
                    m_fl--;
                end
                if (i) m_fl++;
                if (p) m.push_back('{res_addr, res_data});
            end
        end
    end

    initial begin : compare
        logic [2:0] eh;
        forever begin
            @(negedge clk);
            eh = '0;
            foreach (m[k])
                for (int j = 0; j < 3; j++)
                    if (chk_en[j] && m[k].a == chk_addr[j]) eh[j] = 1'b1;
            check("res_ready", res_ready, m.size() < D);
            check("q_valid", wr_req.q_valid, m.size() > m_fl);
            check("hazard", hazard, eh);
            check("empty", empty, m.size() == 0);
            if (m.size() > m_fl) begin
                check("q_addr", wr_req.q.addr, m[m_fl].a);
                check("q_data", wr_req.q.data, m[m_fl].d);
                check("q_fixed", {wr_req.q.write, wr_req.q.strb, wr_req.q.amo, wr_req.q.user},
                      {1'b1, 8'hFF, 4'h0, 1'b0});
            end
        end
    end

    // Responder: answers every accepted write rsp_lat cycles after its issue cycle.
    logic [3:0] pipe = '0;
    logic hs = 1'b0;
    int rsp_lat = 1;
    int n_hs = 0;

    initial forever begin
        @(negedge clk);
        hs = rst_n && wr_req.q_valid && q_ready;
        if (hs) n_hs++;
    end

    initial forever begin
        @(posedge clk);
        pipe = rst_n ? {pipe[2:0], hs} : 4'b0;
        #1 p_valid = rst_n && pipe[rsp_lat-1];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && !empty; i++) step();
        check("drain_empty", empty, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        repeat (3) step();
        check("rst_ready", res_ready, 1'b1);
        check("rst_qvalid", wr_req.q_valid, 1'b0);
        check("rst_hazard", hazard, 3'b000);
        check("rst_empty", empty, 1'b1);
        rst_n = 1'b1;
        step();

        // Single write, 2-cycle response latency
        q_ready = 1'b1;
        rsp_lat = 2;
        chk_addr[0] = 48'h10;
        chk_en = 3'b001;
        step();
        res_valid = 1'b1; res_addr = 48'h10; res_data = 64'hA5;
        #1;
        check("t1_qv_push", wr_req.q_valid, 1'b0);
        check("t1_haz_push", hazard, 3'b000);
        step();
        res_valid = 1'b0;
        #1;
        check("t1_qv", wr_req.q_valid, 1'b1);
        check("t1_addr", wr_req.q.addr, 48'h10);
        check("t1_data", wr_req.q.data, 64'hA5);
        check("t1_haz0", hazard, 3'b001);
        step(); #1;
        check("t1_haz1", hazard, 3'b001);
        check("t1_qv_done", wr_req.q_valid, 1'b0);
        step(); #1;
        check("t1_haz2", hazard, 3'b001);
        step(); #1;
        check("t1_haz_clear", hazard, 3'b000);
        check("t1_empty", empty, 1'b1);

        // Fill with q_ready low, fifth push refused
        chk_en = '0;
        q_ready = 1'b0;
        rsp_lat = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            res_valid = 1'b1; res_addr = 48'h40 + AW'(k); res_data = 64'h1111 * (k + 1);
            #1;
            check("t2_ready", res_ready, k < 4);
            if (k > 0) begin
                check("t2_qv", wr_req.q_valid, 1'b1);
                check("t2_stable", wr_req.q.addr, 48'h40);
            end
        end
        step();
        res_valid = 1'b0;
        q_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_order", wr_req.q.addr, 48'h40 + AW'(k));
            step();
        end
        drain(20);

        // Full buffer, retire and push collide
        q_ready = 1'b0;
        rsp_lat = 2;
        for (int k = 0; k < 4; k++) begin
            step();
            res_valid = 1'b1; res_addr = 48'h50 + AW'(k); res_data = 64'h2222 * (k + 1);
        end
        step();
        res_addr = 48'h54; res_data = 64'h5454;
        q_ready = 1'b1;
        #1; check("t3_full0", res_ready, 1'b0);
        step();
        q_ready = 1'b0;
        #1; check("t3_full1", res_ready, 1'b0);
        step(); #1;
        check("t3_full_retire", res_ready, 1'b0);
        step(); #1;
        check("t3_ready_back", res_ready, 1'b1);
        step();
        res_valid = 1'b0;
        #1;
        check("t3_full_again", res_ready, 1'b0);
        check("t3_not_empty", empty, 1'b0);
        q_ready = 1'b1;
        drain(30);

        // Sustained stream, 1-cycle response latency
        rsp_lat = 1;
        base = n_hs;
        for (int k = 0; k < 16; k++) begin
            step();
            res_valid = 1'b1; res_addr = 48'h100 + AW'(k); res_data = 64'h3000 + 64'(k);
            #1;
            check("t4_ready", res_ready, 1'b1);
            if (k > 0) begin
                check("t4_qv", wr_req.q_valid, 1'b1);
                check("t4_addr", wr_req.q.addr, 48'h100 + AW'(k - 1));
            end
        end
        step();
        res_valid = 1'b0;
        #1;
        check("t4_last", wr_req.q.addr, 48'h10F);
        drain(20);
        check("t4_issued", n_hs - base, 16);

        // Duplicate destination, hazard on operands 0 and 2
        q_ready = 1'b0;
        rsp_lat = 2;
        chk_addr = {48'h20, 48'h20, 48'h20};
        step();
        res_valid = 1'b1; res_addr = 48'h20; res_data = 64'h1;
        step();
        res_data = 64'h2;
        step();
        res_valid = 1'b0;
        chk_en = 3'b101;
        #1; check("t5_haz", hazard, 3'b101);
        chk_en = 3'b000;
        #1; check("t5_haz_off", hazard, 3'b000);
        chk_en = 3'b101;
        q_ready = 1'b1;
        step(); #1;
        check("t5_haz_inflight", hazard, 3'b101);
        drain(20);
        check("t5_haz_clear", hazard, 3'b000);

        // Asynchronous reset with entries stored
        q_ready = 1'b0;
        chk_addr = {48'h62, 48'h61, 48'h60};
        chk_en = 3'b111;
        for (int k = 0; k < 3; k++) begin
            step();
            res_valid = 1'b1; res_addr = 48'h60 + AW'(k); res_data = 64'h6000 + 64'(k);
        end
        step();
        res_valid = 1'b0;
        #1;
        check("t6_haz_pre", hazard, 3'b111);
        check("t6_empty_pre", empty, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_ready", res_ready, 1'b1);
        check("t6_rst_qv", wr_req.q_valid, 1'b0);
        check("t6_rst_haz", hazard, 3'b000);
        check("t6_rst_empty", empty, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        step();
        q_ready = 1'b1;
        rsp_lat = 1;
        res_valid = 1'b1; res_addr = 48'h30; res_data = 64'h3030;
        step();
        res_valid = 1'b0;
        #1;
        check("t6_first_qv", wr_req.q_valid, 1'b1);
        check("t6_first_addr", wr_req.q.addr, 48'h30);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
